lcd_i2c_sequencer: RTL

LCD_I2C_SEQUENCER -- requirements
Module: lcd_i2c_sequencer

---
 rtl/lcd_i2c_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/lcd_i2c_sequencer.sv
// HD44780 4-bit sequencer over a PCF8574 expander: power-up wait, init nibbles, then 4 I2C writes per byte.
// Latency: i2c_start one cycle after accept if the writer is idle; req_ready is low until the post-byte settle delay ends.
module lcd_i2c_sequencer #(
  parameter logic [6:0] SLAVE_ADDR   = 7'h27,
  parameter int         PWRUP_CYCLES = 50000,
  parameter int         LONG_DELAY   = 2000,
  parameter int         SHORT_DELAY  = 100,
  parameter int         TIMEOUT      = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_byte,
  input  logic       backlight,
  output logic       i2c_start,
  output logic [6:0] i2c_addr,
  output logic [7:0] i2c_data,
  input  logic       i2c_busy,
  input  logic       i2c_done,
  output logic       init_done,
  output logic       err
);

  localparam int MAX_A  = (PWRUP_CYCLES > LONG_DELAY) ? PWRUP_CYCLES : LONG_DELAY;
  localparam int MAX_B  = (SHORT_DELAY > TIMEOUT) ? SHORT_DELAY : TIMEOUT;
  localparam int MAX_P  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW_RAW = $clog2(MAX_P + 1);
  localparam int CW     = (CW_RAW < 16) ? 16 : CW_RAW;

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t PWRUP_LAST = cnt_t'(PWRUP_CYCLES - 1);
  localparam cnt_t LONG_LAST  = cnt_t'(LONG_DELAY - 1);
  localparam cnt_t SHORT_LAST = cnt_t'(SHORT_DELAY - 1);
  localparam cnt_t TO_LAST    = cnt_t'(TIMEOUT - 1);

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, ISSUE, WAIT, NEXT, DELAY} state_t;

  state_t     state_q, state_n;
  cnt_t       cnt_q, cnt_n;
  logic [1:0] step_q, step_n;
  logic [1:0] wr_q, wr_n;
  logic       in_init_q, in_init_n;
  logic       rs_q, rs_n;
  logic [7:0] byte_q, byte_n;
  logic [7:0] data_q, data_n;
  logic       init_done_q, init_done_n;
  logic       err_q, err_n;

  logic [3:0] nib;
  logic [7:0] exp_byte;
  logic       last_wr;
  logic       long_dly;
  cnt_t       dly_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PWRUP;
      cnt_q       <= '0;
      step_q      <= 2'd0;
      wr_q        <= 2'd0;
      in_init_q   <= 1'b1;
      rs_q        <= 1'b0;
      byte_q      <= 8'h00;
      data_q      <= 8'h00;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      step_q      <= step_n;
      wr_q        <= wr_n;
      in_init_q   <= in_init_n;
      rs_q        <= rs_n;
      byte_q      <= byte_n;
      data_q      <= data_n;
      init_done_q <= init_done_n;
      err_q       <= err_n;
    end
  end

  // wr_q: bit 1 selects the low nibble, bit 0 marks the EN=0 half of the strobe
  always_comb begin
    if (in_init_q) nib = (step_q == 2'd3) ? 4'h2 : 4'h3;
    else           nib = wr_q[1] ? byte_q[3:0] : byte_q[7:4];
    exp_byte = {nib, backlight, ~wr_q[0], 1'b0, in_init_q ? 1'b0 : rs_q};
    last_wr  = in_init_q ? (wr_q == 2'd1) : (wr_q == 2'd3);
    long_dly = in_init_q ? (step_q == 2'd0)
                         : (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03));
    dly_last = long_dly ? LONG_LAST : SHORT_LAST;
  end

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    step_n      = step_q;
    wr_n        = wr_q;
    in_init_n   = in_init_q;
    rs_n        = rs_q;
    byte_n      = byte_q;
    data_n      = data_q;
    init_done_n = init_done_q;
    err_n       = err_q;
    i2c_start   = 1'b0;
    req_ready   = 1'b0;
    case (state_q)
      PWRUP: begin
        if (cnt_q == PWRUP_LAST) begin
          cnt_n   = '0;
          state_n = INIT;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      INIT: begin
        in_init_n = 1'b1;
        wr_n      = 2'd0;
        state_n   = ISSUE;
      end
      IDLE: begin
        req_ready = init_done_q;
        if (req_valid && init_done_q) begin
          rs_n      = req_rs;
          byte_n    = req_byte;
          wr_n      = 2'd0;
          in_init_n = 1'b0;
          state_n   = ISSUE;
        end
      end
      ISSUE: begin
        if (!i2c_busy) begin
          i2c_start = 1'b1;
          data_n    = exp_byte;
          cnt_n     = cnt_t'(1);
          state_n   = WAIT;
        end
      end
      WAIT: begin
        // the start cycle counts as the first timeout cycle
        if (i2c_done) begin
          state_n = NEXT;
        end else if (cnt_q == TO_LAST) begin
          err_n   = 1'b1;
          cnt_n   = '0;
          state_n = DELAY;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      NEXT: begin
        if (last_wr) begin
          cnt_n   = '0;
          state_n = DELAY;
        end else begin
          wr_n    = wr_q + 2'd1;
          state_n = ISSUE;
        end
      end
      DELAY: begin
        if (cnt_q == dly_last) begin
          cnt_n = '0;
          if (in_init_q && step_q != 2'd3) begin
            step_n  = step_q + 2'd1;
            state_n = INIT;
          end else begin
            if (in_init_q) init_done_n = 1'b1;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: state_n = PWRUP;
    endcase
  end

  assign i2c_addr  = SLAVE_ADDR;
  assign i2c_data  = i2c_start ? exp_byte : data_q;
  assign init_done = init_done_q;
  assign err       = err_q;

endmodule
